// File: rtl/ifu_fetch_queue.sv
// Instruction-fetch queue: issues IM word reads for pc_in, buffers {pc, instr} in a small FIFO
// and hands the head to decode over valid/ready. pc_ready is only raised when a FIFO slot is
// reserved for the fetch, so a push can never overflow.
// Optional macro IFU_FETCH_EXC_EN adds dec_exc and flags misaligned / out-of-range PCs.
module ifu_fetch_queue #(
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned IM_WORDS  = 4096,
    parameter int unsigned AW        = 12,
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   pc_in,
    output logic          pc_ready,
    output logic          im_en,
    output logic [AW-1:0] im_addr,
    input  logic [31:0]   im_rdata,
    input  logic          flush,
    output logic          dec_valid,
    input  logic          dec_ready,
    output logic [31:0]   dec_instr,
    output logic [31:0]   dec_pc
`ifdef IFU_FETCH_EXC_EN
    ,
    output logic          dec_exc
`endif
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    // First byte address past the end of the IM, widened so it cannot wrap.
    localparam logic [32:0] IM_LIMIT = {1'b0, BASE_ADDR} + 33'(4 * IM_WORDS);

    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          r_inflight;
    logic [31:0]   r_inflight_pc;
    logic [31:0]   r_pc_mem    [DEPTH];
    logic [31:0]   r_instr_mem [DEPTH];

    logic          w_pop;
    logic          w_push;
    logic [CW:0]   w_occ;
    logic [31:0]   w_offset;
    logic [31:0]   w_push_instr;
    logic          w_unused;

`ifdef IFU_FETCH_EXC_EN
    logic r_inflight_exc;
    logic r_exc_mem [DEPTH];
    logic w_fault;
`endif

    // Handshake, space reservation and IM request decode.
    always_comb begin
        dec_valid = !reset && (r_count != '0);
        w_pop     = dec_valid && dec_ready;
        w_push    = r_inflight && !flush && !reset;
        // Slots already owned (stored + in flight) minus the one leaving this cycle.
        w_occ     = {1'b0, r_count} + (CW + 1)'(r_inflight) - (CW + 1)'(w_pop);
        pc_ready  = !reset && !flush && (w_occ < (CW + 1)'(DEPTH));
        w_offset  = pc_in - BASE_ADDR;
        im_addr   = reset ? '0 : w_offset[AW+1:2];
`ifdef IFU_FETCH_EXC_EN
        w_fault   = (pc_in[1:0] != 2'b00) || (pc_in < BASE_ADDR) ||
                    ({1'b0, pc_in} >= IM_LIMIT);
        im_en     = pc_ready && !w_fault;
        w_push_instr = r_inflight_exc ? 32'h0000_0000 : im_rdata;
        w_unused  = ^{w_offset[31:AW+2], w_offset[1:0]};
`else
        im_en     = pc_ready;
        w_push_instr = im_rdata;
        w_unused  = ^{w_offset[31:AW+2], w_offset[1:0], IM_LIMIT};
`endif
    end

    // Head presentation; outputs are forced to zero whenever the head is not valid.
    always_comb begin
        dec_pc    = dec_valid ? r_pc_mem[r_rd_ptr] : 32'h0000_0000;
        dec_instr = dec_valid ? r_instr_mem[r_rd_ptr] : 32'h0000_0000;
`ifdef IFU_FETCH_EXC_EN
        dec_exc   = dec_valid ? r_exc_mem[r_rd_ptr] : 1'b0;
`endif
    end

    // Control state: reset and flush both discard buffered and in-flight fetches.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_inflight    <= 1'b0;
            r_inflight_pc <= 32'h0000_0000;
`ifdef IFU_FETCH_EXC_EN
            r_inflight_exc <= 1'b0;
`endif
        end else begin
            r_inflight <= pc_ready;
            if (pc_ready) begin
                r_inflight_pc <= pc_in;
`ifdef IFU_FETCH_EXC_EN
                r_inflight_exc <= w_fault;
`endif
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // FIFO storage; contents need no reset since they are masked by dec_valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]    <= r_inflight_pc;
            r_instr_mem[r_wr_ptr] <= w_push_instr;
`ifdef IFU_FETCH_EXC_EN
            r_exc_mem[r_wr_ptr]   <= r_inflight_exc;
`endif
        end
    end

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Directed self-checking bench for ifu_fetch_queue (DEPTH=2, IM_WORDS=4096).
// IM model: word k returns 0x1000_0000 + k one cycle after im_en.
module tb_ifu_fetch_queue;

    logic        clk;
    logic        reset;
    logic [31:0] pc_in;
    logic        pc_ready;
    logic        im_en;
    logic [11:0] im_addr;
    logic [31:0] im_rdata;
    logic        flush;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
`ifdef IFU_FETCH_EXC_EN
    logic        dec_exc;
`endif

    int checks;
    int errors;
    logic auto_pc;

    ifu_fetch_queue #(
        .DEPTH     (2),
        .IM_WORDS  (4096),
        .AW        (12),
        .BASE_ADDR (32'h0000_3000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pc_in     (pc_in),
        .pc_ready  (pc_ready),
        .im_en     (im_en),
        .im_addr   (im_addr),
        .im_rdata  (im_rdata),
        .flush     (flush),
        .dec_valid (dec_valid),
        .dec_ready (dec_ready),
        .dec_instr (dec_instr),
        .dec_pc    (dec_pc)
`ifdef IFU_FETCH_EXC_EN
        ,
        .dec_exc   (dec_exc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read instruction memory model.
    always @(posedge clk) begin
        if (im_en) im_rdata <= 32'h1000_0000 + {20'h0, im_addr};
    end

    // One clock: PC register advances after an accepted fetch when auto_pc is set.
    task automatic step();
        logic acc;
        #1;
        acc = pc_ready;
        @(posedge clk);
        #1;
        if (auto_pc && acc) pc_in = pc_in + 32'd4;
        #1;
    endtask

    task automatic test_reset();
        step();
        step();
        checks++; if (pc_ready !== 1'b0) begin errors++; $display("FAIL reset_pc_ready: got %b exp 0", pc_ready); end
        checks++; if (im_en !== 1'b0) begin errors++; $display("FAIL reset_im_en: got %b exp 0", im_en); end
        checks++; if (im_addr !== 12'h000) begin errors++; $display("FAIL reset_im_addr: got %h exp 000", im_addr); end
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL reset_dec_valid: got %b exp 0", dec_valid); end
        checks++; if (dec_instr !== 32'h0) begin errors++; $display("FAIL reset_dec_instr: got %h exp 0", dec_instr); end
        checks++; if (dec_pc !== 32'h0) begin errors++; $display("FAIL reset_dec_pc: got %h exp 0", dec_pc); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        logic [31:0] exp_in;
        reset = 1'b0;
        pc_in = 32'h3000;
        auto_pc = 1'b1;
        dec_ready = 1'b1;
        #1;
        checks++; if (pc_ready !== 1'b1) begin errors++; $display("FAIL stream_first_ready: got %b exp 1", pc_ready); end
        checks++; if (im_en !== 1'b1) begin errors++; $display("FAIL stream_first_im_en: got %b exp 1", im_en); end
        checks++; if (im_addr !== 12'h000) begin errors++; $display("FAIL stream_first_addr: got %h exp 000", im_addr); end
        step();
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL stream_latency_t1: got %b exp 0", dec_valid); end
        step();
        for (int k = 0; k < 8; k++) begin
            exp_pc = 32'h3000 + 32'(k) * 4;
            exp_in = 32'h1000_0000 + 32'(k);
            checks++; if (dec_valid !== 1'b1) begin errors++; $display("FAIL stream_valid k=%0d: got %b exp 1", k, dec_valid); end
            checks++; if (dec_pc !== exp_pc) begin errors++; $display("FAIL stream_pc k=%0d: got %h exp %h", k, dec_pc, exp_pc); end
            checks++; if (dec_instr !== exp_in) begin errors++; $display("FAIL stream_instr k=%0d: got %h exp %h", k, dec_instr, exp_in); end
            checks++; if (pc_ready !== 1'b1) begin errors++; $display("FAIL stream_ready k=%0d: got %b exp 1", k, pc_ready); end
            step();
        end
    endtask

    // Entry state: head 0x3020 stored, 0x3024 in flight, pc_in 0x3028.
    task automatic test_back_pressure();
        logic [31:0] exp_pc;
        logic [31:0] exp_in;
        dec_ready = 1'b0;
        #1;
        checks++; if (pc_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_drop: got %b exp 0", pc_ready); end
        for (int c = 0; c < 5; c++) begin
            step();
            checks++; if (dec_valid !== 1'b1) begin errors++; $display("FAIL bp_valid c=%0d: got %b exp 1", c, dec_valid); end
            checks++; if (dec_pc !== 32'h3020) begin errors++; $display("FAIL bp_head c=%0d: got %h exp 00003020", c, dec_pc); end
            checks++; if (pc_ready !== 1'b0) begin errors++; $display("FAIL bp_ready c=%0d: got %b exp 0", c, pc_ready); end
        end
        // Full FIFO with a pop frees one slot in the same cycle.
        dec_ready = 1'b1;
        #1;
        checks++; if (pc_ready !== 1'b1) begin errors++; $display("FAIL bp_full_pop_ready: got %b exp 1", pc_ready); end
        checks++; if (im_addr !== 12'h00A) begin errors++; $display("FAIL bp_resume_addr: got %h exp 00a", im_addr); end
        for (int k = 8; k < 13; k++) begin
            exp_pc = 32'h3000 + 32'(k) * 4;
            exp_in = 32'h1000_0000 + 32'(k);
            checks++; if (dec_pc !== exp_pc) begin errors++; $display("FAIL bp_order k=%0d: got %h exp %h", k, dec_pc, exp_pc); end
            checks++; if (dec_instr !== exp_in) begin errors++; $display("FAIL bp_instr k=%0d: got %h exp %h", k, dec_instr, exp_in); end
            checks++; if (pc_ready !== 1'b1) begin errors++; $display("FAIL bp_resume_ready k=%0d: got %b exp 1", k, pc_ready); end
            step();
        end
    endtask

    // Entry state: one entry stored and one fetch in flight.
    task automatic test_flush();
        flush = 1'b1;
        auto_pc = 1'b0;
        pc_in = 32'h3100;
        #1;
        checks++; if (pc_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b exp 0", pc_ready); end
        checks++; if (im_en !== 1'b0) begin errors++; $display("FAIL flush_im_en: got %b exp 0", im_en); end
        step();
        flush = 1'b0;
        auto_pc = 1'b1;
        #1;
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL flush_after_valid: got %b exp 0", dec_valid); end
        checks++; if (dec_pc !== 32'h0) begin errors++; $display("FAIL flush_after_pc: got %h exp 0", dec_pc); end
        checks++; if (pc_ready !== 1'b1) begin errors++; $display("FAIL flush_after_ready: got %b exp 1", pc_ready); end
        checks++; if (im_addr !== 12'h040) begin errors++; $display("FAIL flush_redirect_addr: got %h exp 040", im_addr); end
        step();
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL flush_t1_valid: got %b exp 0", dec_valid); end
        step();
        checks++; if (dec_valid !== 1'b1) begin errors++; $display("FAIL flush_t2_valid: got %b exp 1", dec_valid); end
        checks++; if (dec_pc !== 32'h3100) begin errors++; $display("FAIL flush_t2_pc: got %h exp 00003100", dec_pc); end
        checks++; if (dec_instr !== 32'h1000_0040) begin errors++; $display("FAIL flush_t2_instr: got %h exp 10000040", dec_instr); end
        step();
        checks++; if (dec_pc !== 32'h3104) begin errors++; $display("FAIL flush_t3_pc: got %h exp 00003104", dec_pc); end
    endtask

    // Entry state: one entry stored and one fetch in flight.
    task automatic test_reset_mid();
        reset = 1'b1;
        #1;
        checks++; if (pc_ready !== 1'b0) begin errors++; $display("FAIL rmid_ready: got %b exp 0", pc_ready); end
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b exp 0", dec_valid); end
        step();
        checks++; if (im_en !== 1'b0) begin errors++; $display("FAIL rmid_im_en: got %b exp 0", im_en); end
        checks++; if (im_addr !== 12'h000) begin errors++; $display("FAIL rmid_im_addr: got %h exp 000", im_addr); end
        checks++; if (dec_instr !== 32'h0) begin errors++; $display("FAIL rmid_instr: got %h exp 0", dec_instr); end
        reset = 1'b0;
        pc_in = 32'h3000;
        #1;
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL rmid_post_valid: got %b exp 0", dec_valid); end
        checks++; if (dec_pc !== 32'h0) begin errors++; $display("FAIL rmid_post_pc: got %h exp 0", dec_pc); end
        checks++; if (pc_ready !== 1'b1) begin errors++; $display("FAIL rmid_post_ready: got %b exp 1", pc_ready); end
        step();
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL rmid_t1_valid: got %b exp 0", dec_valid); end
        step();
        checks++; if (dec_valid !== 1'b1) begin errors++; $display("FAIL rmid_t2_valid: got %b exp 1", dec_valid); end
        checks++; if (dec_pc !== 32'h3000) begin errors++; $display("FAIL rmid_t2_pc: got %h exp 00003000", dec_pc); end
        checks++; if (dec_instr !== 32'h1000_0000) begin errors++; $display("FAIL rmid_t2_instr: got %h exp 10000000", dec_instr); end
    endtask

`ifdef IFU_FETCH_EXC_EN
    task automatic test_exc();
        reset = 1'b1;
        auto_pc = 1'b0;
        step();
        reset = 1'b0;
        dec_ready = 1'b1;
        pc_in = 32'h3002;
        #1;
        checks++; if (pc_ready !== 1'b1) begin errors++; $display("FAIL exc_misalign_ready: got %b exp 1", pc_ready); end
        checks++; if (im_en !== 1'b0) begin errors++; $display("FAIL exc_misalign_im_en: got %b exp 0", im_en); end
        step();
        pc_in = 32'h2FFC;
        #1;
        checks++; if (im_en !== 1'b0) begin errors++; $display("FAIL exc_below_im_en: got %b exp 0", im_en); end
        step();
        checks++; if (dec_exc !== 1'b1) begin errors++; $display("FAIL exc_misalign_exc: got %b exp 1", dec_exc); end
        checks++; if (dec_pc !== 32'h3002) begin errors++; $display("FAIL exc_misalign_pc: got %h exp 00003002", dec_pc); end
        checks++; if (dec_instr !== 32'h0) begin errors++; $display("FAIL exc_misalign_instr: got %h exp 0", dec_instr); end
        pc_in = 32'h7000;
        #1;
        checks++; if (im_en !== 1'b0) begin errors++; $display("FAIL exc_above_im_en: got %b exp 0", im_en); end
        step();
        checks++; if (dec_exc !== 1'b1) begin errors++; $display("FAIL exc_below_exc: got %b exp 1", dec_exc); end
        checks++; if (dec_pc !== 32'h2FFC) begin errors++; $display("FAIL exc_below_pc: got %h exp 00002ffc", dec_pc); end
        checks++; if (dec_instr !== 32'h0) begin errors++; $display("FAIL exc_below_instr: got %h exp 0", dec_instr); end
        pc_in = 32'h3004;
        #1;
        checks++; if (im_en !== 1'b1) begin errors++; $display("FAIL exc_good_im_en: got %b exp 1", im_en); end
        step();
        checks++; if (dec_exc !== 1'b1) begin errors++; $display("FAIL exc_above_exc: got %b exp 1", dec_exc); end
        checks++; if (dec_pc !== 32'h7000) begin errors++; $display("FAIL exc_above_pc: got %h exp 00007000", dec_pc); end
        checks++; if (dec_instr !== 32'h0) begin errors++; $display("FAIL exc_above_instr: got %h exp 0", dec_instr); end
        step();
        checks++; if (dec_exc !== 1'b0) begin errors++; $display("FAIL exc_good_exc: got %b exp 0", dec_exc); end
        checks++; if (dec_pc !== 32'h3004) begin errors++; $display("FAIL exc_good_pc: got %h exp 00003004", dec_pc); end
        checks++; if (dec_instr !== 32'h1000_0001) begin errors++; $display("FAIL exc_good_instr: got %h exp 10000001", dec_instr); end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        flush = 1'b0;
        dec_ready = 1'b0;
        pc_in = 32'h3000;
        auto_pc = 1'b0;
        test_reset();
        test_stream();
        test_back_pressure();
        test_flush();
        test_reset_mid();
`ifdef IFU_FETCH_EXC_EN
        test_exc();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
